// File: rtl/sdram_rw_scheduler_if.sv
// sdram_rw_scheduler_if: FIFO levels, frame pulses and burst handshake between scheduler and SDRAM side
interface sdram_rw_scheduler_if #(parameter int ADDR_W = 22);
  logic sdr_init_done;
  logic [10:0] wr_fifo_usedw;
  logic [10:0] rd_fifo_usedw;
  logic cam_frame_start;
  logic vga_frame_start;
  logic sdr_wr_req;
  logic sdr_rd_req;
  logic [ADDR_W-1:0] sdr_addr;
  logic sdr_ack;
  logic sdr_done;
  logic busy;
  modport master (
    output sdr_init_done, wr_fifo_usedw, rd_fifo_usedw, cam_frame_start, vga_frame_start, sdr_ack, sdr_done,
    input sdr_wr_req, sdr_rd_req, sdr_addr, busy
  );
  modport slave (
    input sdr_init_done, wr_fifo_usedw, rd_fifo_usedw, cam_frame_start, vga_frame_start, sdr_ack, sdr_done,
    output sdr_wr_req, sdr_rd_req, sdr_addr, busy
  );
endinterface

// File: rtl/sdram_rw_scheduler.sv
// sdram_rw_scheduler: arbitrates camera write and VGA read bursts over two ping-pong SDRAM frame banks
module sdram_rw_scheduler #(
  parameter int BURST_LEN = 256,
  parameter int FRAME_WORDS = 76800,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int RD_URGENT = 128,
  parameter int ADDR_W = 22
) (
  input logic clk,
  input logic rst_n,
  sdram_rw_scheduler_if.slave bus
);
  localparam int OW = ADDR_W - 1;
  localparam logic [10:0] BL_W = 11'(BURST_LEN);
  localparam logic [10:0] URG = 11'(RD_URGENT);
  localparam logic [10:0] RD_MAX = 11'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [OW-1:0] BL = OW'(BURST_LEN);
  localparam logic [OW-1:0] FW = OW'(FRAME_WORDS);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
  state_t state, state_n;
  logic [OW-1:0] wr_off, rd_off, off_adv;
  logic wr_bank, rd_bank, last_wr, cam_pend, vga_pend;
  logic rd_urgent, wr_ok, rd_ok, done_wr, done_rd, wrap;
  always_comb begin
    rd_urgent = bus.rd_fifo_usedw < URG;
    wr_ok = bus.wr_fifo_usedw >= BL_W;
    rd_ok = bus.rd_fifo_usedw <= RD_MAX;
    done_wr = state == WR_WAIT && bus.sdr_done;
    done_rd = state == RD_WAIT && bus.sdr_done;
    off_adv = (state == WR_WAIT ? wr_off : rd_off) + BL;
    wrap = off_adv == FW;
    state_n = state;
    case (state)
      // a pending frame start is applied in its own IDLE cycle so the next address sees it
      IDLE: if (!(cam_pend || vga_pend) && bus.sdr_init_done)
        state_n = rd_urgent ? RD_REQ : (wr_ok && rd_ok) ? (last_wr ? RD_REQ : WR_REQ) :
                  wr_ok ? WR_REQ : rd_ok ? RD_REQ : IDLE;
      WR_REQ: if (bus.sdr_ack) state_n = WR_WAIT;
      RD_REQ: if (bus.sdr_ack) state_n = RD_WAIT;
      WR_WAIT, RD_WAIT: if (bus.sdr_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.sdr_wr_req <= 1'b0;
      bus.sdr_rd_req <= 1'b0;
      bus.busy <= 1'b0;
      bus.sdr_addr <= '0;
      wr_off <= '0;
      rd_off <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b1;
      last_wr <= 1'b0;
      cam_pend <= 1'b0;
      vga_pend <= 1'b0;
    end else begin
      state <= state_n;
      bus.sdr_wr_req <= state_n == WR_REQ;
      bus.sdr_rd_req <= state_n == RD_REQ;
      bus.busy <= state_n != IDLE;
      cam_pend <= (state == IDLE && cam_pend) ? 1'b0 : cam_pend | bus.cam_frame_start;
      vga_pend <= (state == IDLE && vga_pend) ? 1'b0 : vga_pend | bus.vga_frame_start;
      if (state == IDLE && state_n != IDLE) begin
        last_wr <= state_n == WR_REQ;
        bus.sdr_addr <= state_n == WR_REQ ? {wr_bank, wr_off} : {rd_bank, rd_off};
      end
      if (done_wr) begin
        wr_off <= wrap ? '0 : off_adv;
        if (wrap) wr_bank <= ~wr_bank;
      end
      // reader follows onto the bank the writer has just finished
      if (done_rd) begin
        rd_off <= wrap ? '0 : off_adv;
        if (wrap) rd_bank <= ~wr_bank;
      end
      if (state == IDLE && cam_pend) begin
        wr_off <= '0;
        if (wr_off != '0) wr_bank <= ~wr_bank;
      end
      if (state == IDLE && vga_pend) begin
        rd_off <= '0;
        if (rd_off != '0) rd_bank <= ~wr_bank;
      end
    end
endmodule

// File: doc/sdram_rw_scheduler.md
SDRAM_RW_SCHEDULER -- requirements
Module: sdram_rw_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BURST_LEN, 256, words per SDRAM burst.
- FRAME_WORDS, 76800, words per frame (320x240); SHALL be a multiple of BURST_LEN.
- RD_FIFO_DEPTH, 1024, read-FIFO capacity in words.
- RD_URGENT, 128, read-FIFO level below which a read is urgent.
- ADDR_W, 22, SDRAM word-address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- sdr_init_done, in, 1, SDRAM controller initialised.
- wr_fifo_usedw, in, 11, words held in the camera write FIFO.
- rd_fifo_usedw, in, 11, words held in the VGA read FIFO.
- cam_frame_start, in, 1, one-cycle pulse at camera frame start.
- vga_frame_start, in, 1, one-cycle pulse at VGA frame start.
- sdr_wr_req, out, 1, burst-write request.
- sdr_rd_req, out, 1, burst-read request.
- sdr_addr, out, ADDR_W, burst start word address.
- sdr_ack, in, 1, controller accepted the pending request.
- sdr_done, in, 1, one-cycle pulse when the burst completes.
- busy, out, 1, burst in progress.
REQ-003 The block SHALL use one clock, clk; rst_n SHALL be asynchronous and active-low; all outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have the states IDLE, WR_REQ, WR_WAIT, RD_REQ and RD_WAIT.
REQ-005 In IDLE with sdr_init_done=0, the FSM SHALL remain in IDLE.
REQ-006 Arbitration in IDLE SHALL apply these rules in priority order:
- (a) rd_urgent (rd_fifo_usedw < RD_URGENT) -> RD_REQ.
- (b) wr_ok (wr_fifo_usedw >= BURST_LEN) and rd_ok (rd_fifo_usedw <= RD_FIFO_DEPTH-BURST_LEN) both true -> the opposite of last_served.
- (c) wr_ok alone -> WR_REQ.
- (d) rd_ok alone -> RD_REQ.
- Otherwise the FSM SHALL stay in IDLE.
REQ-007 last_served SHALL reset to READ and SHALL update on each IDLE exit.
REQ-008 sdr_wr_req (respectively sdr_rd_req) SHALL be 1 throughout WR_REQ (respectively RD_REQ), and the two SHALL never both be 1.
REQ-009 sdr_addr SHALL be valid and stable from the request cycle until sdr_ack.
REQ-010 An xx_REQ state SHALL go to xx_WAIT on the cycle sdr_ack=1 is sampled, and the request SHALL drop on the next edge.
REQ-011 An xx_WAIT state SHALL return to IDLE on sdr_done=1; busy SHALL be 1 in all non-IDLE states.
REQ-012 The address SHALL be {bank, offset}:
- Writes SHALL use wr_bank and wr_off.
- Reads SHALL use rd_bank and rd_off.
- The bank bit SHALL be address bit ADDR_W-1.
- The offset SHALL be zero-extended into the low bits.
REQ-013 On sdr_done, the served offset SHALL advance by BURST_LEN.
REQ-014 When the advanced offset equals FRAME_WORDS, the offset SHALL wrap to 0.
REQ-015 A write wrap SHALL toggle wr_bank.
REQ-016 A read wrap SHALL load rd_bank <= ~wr_bank, so the reader takes the most recently completed bank.
REQ-017 cam_frame_start SHALL set a pending flag; in IDLE the flag SHALL clear wr_off to 0 and toggle wr_bank only if wr_off != 0, then clear the flag.
REQ-018 vga_frame_start SHALL be handled the same way for rd_off, with rd_bank <= ~wr_bank.
REQ-019 A frame-start pulse arriving while not in IDLE SHALL be deferred until the next IDLE and SHALL NOT corrupt the burst in flight.
REQ-020 A frame-start pulse and sdr_done in the same cycle SHALL both take effect: the wrap/advance first, then the pending flag is applied in IDLE.
REQ-021 A repeated frame-start pulse while the flag is already pending SHALL have no additional effect.
REQ-022 sdr_ack outside an xx_REQ state and sdr_done outside an xx_WAIT state SHALL be ignored.

Reset
REQ-023 On rst_n=0, the block SHALL immediately set:
- state=IDLE;
- sdr_wr_req=0, sdr_rd_req=0, busy=0;
- sdr_addr=0;
- wr_off=0, rd_off=0;
- wr_bank=0, rd_bank=1;
- last_served=READ;
- both pending flags=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst, with no offset update.
REQ-025 After rst_n deasserts, the first request SHALL occur no earlier than the first clk edge with sdr_init_done=1.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Init gate: sdr_init_done=0, wr_fifo_usedw=300 -> no request for 100 cycles; raise init_done -> sdr_wr_req=1 with sdr_addr=0 within 2 cycles.
- Urgent read: wr_fifo_usedw=512, rd_fifo_usedw=50 -> sdr_rd_req first at sdr_addr=0x200000 (rd_bank=1).
- Round-robin: wr_fifo_usedw=512, rd_fifo_usedw=500 held -> requests alternate W,R,W,R; write addresses 0,256,512.
- Wrap: 300 write bursts complete -> wr_off=0, wr_bank=1, next write sdr_addr=0x200000; read wrap afterwards -> rd_bank=0.
- Deferred frame start: cam_frame_start during WR_WAIT at wr_off=1024 -> the burst finishes, then wr_off=0 and wr_bank toggles; the next write is at the new bank base.
- Reset mid-burst: rst_n low in RD_WAIT -> requests and busy=0 immediately; after release the first read is at 0x200000.
